hamming_decode_scheduler: RTL and testbench

Shares one combinational 21-bit Hamming SEC decode core between NUM_REQ requesters.
- Round-robin arbitration over valid/ready request ports.
- Two-stage registered pipeline into a single valid/ready output stream tagged with the source index.
- Saturating statistics counters for decoded, corrected and uncorrectable words.
- Sits between the link receive buffers and the payload consumers.

---
 rtl/hamming_pkg.sv | 44 ++++
 rtl/hamming_decode_scheduler_if.sv | 40 ++++
 rtl/hamming_sec_core.sv | 38 +++
 rtl/hamming_decode_scheduler.sv | 157 +++++++++++++++
 tb/tb_hamming_decode_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_pkg.sv
// Shared constants, codeword layout and decode result types for the
// 21-bit Hamming SEC decode scheduler.
package hamming_pkg;

    localparam int CW_W    = 21;
    localparam int DATA_W  = 16;
    localparam int SYN_W   = 5;
    localparam int NUM_PAR = 5;

    // Hamming positions are 1-based; codeword bit k carries position k+1.
    localparam int PARITY_POS [NUM_PAR] = '{1, 2, 4, 8, 16};
    localparam int DATA_POS   [DATA_W]  = '{3, 5, 6, 7, 9, 10, 11, 12,
                                            13, 14, 15, 17, 18, 19, 20, 21};

    typedef enum logic [1:0] {
        SYN_NONE,
        SYN_PARITY,
        SYN_DATA,
        SYN_UNCORR
    } syn_class_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SYN_W-1:0]  syndrome;
        logic              corrected;
        logic              uncorr;
    } dec_result_t;

    function automatic syn_class_e classify(logic [SYN_W-1:0] syn);
        syn_class_e c;
        if (syn == '0) begin
            c = SYN_NONE;
        end else if (syn > SYN_W'(CW_W)) begin
            c = SYN_UNCORR;
        end else begin
            c = SYN_DATA;
            for (int j = 0; j < NUM_PAR; j++) begin
                if (syn == SYN_W'(PARITY_POS[j])) c = SYN_PARITY;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/hamming_decode_scheduler_if.sv
// Request, output-stream and statistics bundle of the decode scheduler.
// master = environment side, slave = scheduler side.
interface hamming_decode_scheduler_if #(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 16
);
    import hamming_pkg::*;

    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*CW_W-1:0] req_cw;
    logic [NUM_REQ-1:0]      req_ready;

    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic [SRC_W-1:0]        out_src;
    logic [SYN_W-1:0]        out_syndrome;
    logic                    out_corrected;
    logic                    out_uncorr;

    logic                    stat_clr;
    logic [CNT_W-1:0]        stat_words;
    logic [CNT_W-1:0]        stat_corr;
    logic [CNT_W-1:0]        stat_uncorr;

    modport master (
        output req_valid, req_cw, out_ready, stat_clr,
        input  req_ready, out_valid, out_data, out_src, out_syndrome,
               out_corrected, out_uncorr, stat_words, stat_corr, stat_uncorr
    );

    modport slave (
        input  req_valid, req_cw, out_ready, stat_clr,
        output req_ready, out_valid, out_data, out_src, out_syndrome,
               out_corrected, out_uncorr, stat_words, stat_corr, stat_uncorr
    );

endinterface

// File: rtl/hamming_sec_core.sv
// Combinational Hamming SEC decoder: syndrome, classification and
// single-bit data correction for one 21-bit codeword.
module hamming_sec_core
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]   cw,
    output logic [DATA_W-1:0] data,
    output logic [SYN_W-1:0]  syndrome,
    output logic              corrected,
    output logic              uncorr
);

    logic [SYN_W-1:0] syn_acc;
    syn_class_e       syn_class;

    // NOTE: every output of a combinational block gets a default before any
    // conditional logic so no path leaves it unassigned (no latch inferred).
    always_comb begin
        syn_acc = '0;
        for (int k = 0; k < CW_W; k++) begin
            if (cw[k]) syn_acc = syn_acc ^ SYN_W'(k + 1);
        end
        syn_class = classify(syn_acc);

        data = '0;
        for (int i = 0; i < DATA_W; i++) begin
            data[i] = cw[DATA_POS[i] - 1];
            if (syn_class == SYN_DATA && syn_acc == SYN_W'(DATA_POS[i])) begin
                data[i] = ~cw[DATA_POS[i] - 1];
            end
        end
    end

    assign syndrome  = syn_acc;
    assign corrected = (syn_class == SYN_PARITY) || (syn_class == SYN_DATA);
    assign uncorr    = (syn_class == SYN_UNCORR);

endmodule

// File: rtl/hamming_decode_scheduler.sv
// Round-robin front end sharing one SEC decode core between NUM_REQ
// requesters, with a two-stage output pipeline and saturating statistics.
module hamming_decode_scheduler
    import hamming_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    hamming_decode_scheduler_if.slave  bus
);

    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [SRC_W-1:0] PTR_RST = SRC_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v, logic en);
        return (en && v != CNT_MAX) ? v + CNT_W'(1) : v;
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic [CW_W-1:0]   s1_cw_q,    s1_cw_d;
    logic [SRC_W-1:0]  s1_src_q,   s1_src_d;
    logic              s2_valid_q, s2_valid_d;
    dec_result_t       s2_res_q,   s2_res_d;
    logic [SRC_W-1:0]  s2_src_q,   s2_src_d;
    logic [SRC_W-1:0]  ptr_q,      ptr_d;
    logic [CNT_W-1:0]  words_q,    words_d;
    logic [CNT_W-1:0]  corr_q,     corr_d;
    logic [CNT_W-1:0]  uncorr_q,   uncorr_d;

    logic              grant_found;
    logic [SRC_W-1:0]  grant_idx;
    logic [CW_W-1:0]   grant_cw;
    logic              s1_advance, s1_open, take, transfer;
    logic [NUM_REQ-1:0] ready_w;
    dec_result_t       core_res;

    hamming_sec_core u_core (
        .cw        (s1_cw_q),
        .data      (core_res.data),
        .syndrome  (core_res.syndrome),
        .corrected (core_res.corrected),
        .uncorr    (core_res.uncorr)
    );

    // Search indices above the pointer first, then wrap to the low ones.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && bus.req_valid[i] && (i > int'(ptr_q))) begin
                grant_found = 1'b1;
                grant_idx   = SRC_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && bus.req_valid[i] && (i <= int'(ptr_q))) begin
                grant_found = 1'b1;
                grant_idx   = SRC_W'(i);
            end
        end
    end

    assign s1_advance = s1_valid_q && (!s2_valid_q || bus.out_ready);
    assign s1_open    = !rst && (!s1_valid_q || s1_advance);
    assign take       = grant_found && s1_open;
    assign transfer   = s2_valid_q && bus.out_ready;

    always_comb begin
        ready_w  = '0;
        grant_cw = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == SRC_W'(i)) begin
                ready_w[i] = take;
                grant_cw   = bus.req_cw[i*CW_W +: CW_W];
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_cw_d    = s1_cw_q;
        s1_src_d   = s1_src_q;
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_src_d   = s2_src_q;
        ptr_d      = ptr_q;

        if (s1_advance) s1_valid_d = 1'b0;
        if (take) begin
            s1_valid_d = 1'b1;
            s1_cw_d    = grant_cw;
            s1_src_d   = grant_idx;
            ptr_d      = grant_idx;
        end

        if (transfer) s2_valid_d = 1'b0;
        if (s1_advance) begin
            s2_valid_d = 1'b1;
            s2_res_d   = core_res;
            s2_src_d   = s1_src_q;
        end

        // A clear wins over the increment of a word leaving in the same cycle.
        if (bus.stat_clr) begin
            words_d  = '0;
            corr_d   = '0;
            uncorr_d = '0;
        end else begin
            words_d  = sat_inc(words_q,  transfer);
            corr_d   = sat_inc(corr_q,   transfer && s2_res_q.corrected);
            uncorr_d = sat_inc(uncorr_q, transfer && s2_res_q.uncorr);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_cw_q    <= '0;
            s1_src_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_src_q   <= '0;
            ptr_q      <= PTR_RST;
            words_q    <= '0;
            corr_q     <= '0;
            uncorr_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_cw_q    <= s1_cw_d;
            s1_src_q   <= s1_src_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_src_q   <= s2_src_d;
            ptr_q      <= ptr_d;
            words_q    <= words_d;
            corr_q     <= corr_d;
            uncorr_q   <= uncorr_d;
        end
    end

    assign bus.req_ready     = ready_w;
    assign bus.out_valid     = s2_valid_q;
    assign bus.out_data      = s2_res_q.data;
    assign bus.out_syndrome  = s2_res_q.syndrome;
    assign bus.out_corrected = s2_res_q.corrected;
    assign bus.out_uncorr    = s2_res_q.uncorr;
    assign bus.out_src       = s2_src_q;
    assign bus.stat_words    = words_q;
    assign bus.stat_corr     = corr_q;
    assign bus.stat_uncorr   = uncorr_q;

endmodule

// File: tb/tb_hamming_decode_scheduler.sv
// Directed bench for hamming_decode_scheduler: scoreboard of independently
// decoded words, round-robin and hold checks, counter and reset scenarios.
module tb_hamming_decode_scheduler;

    localparam int NUM_REQ = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  syn;
        logic        corr;
        logic        unc;
        int          src;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;
    exp_t sb[$];
    int   m_words, m_corr, m_unc;
    int   rr_ptr;
    logic have_prev;
    logic prev_stall;
    logic [31:0] prev_sig;

    hamming_decode_scheduler_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

    hamming_decode_scheduler #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode: flip the erroneous position in the whole codeword,
    // then read the data bits out of the non-power-of-two positions.
    function automatic exp_t model(logic [20:0] cw, int src);
        exp_t        e;
        logic [21:0] p;
        int          s;
        int          k;
        p = {cw, 1'b0};
        s = 0;
        for (int j = 0; j < 5; j++) begin
            logic b;
            b = 1'b0;
            for (int pos = 1; pos <= 21; pos++) if (((pos >> j) & 1) == 1) b = b ^ p[pos];
            if (b) s = s | (1 << j);
        end
        e.syn  = 5'(s);
        e.corr = (s >= 1 && s <= 21);
        e.unc  = (s >= 22);
        e.src  = src;
        if (e.corr) p[s] = ~p[s];
        e.data = '0;
        k = 0;
        for (int pos = 1; pos <= 21; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                e.data[k] = p[pos];
                k++;
            end
        end
        return e;
    endfunction

    function automatic int rr_expect(int ptr, logic [NUM_REQ-1:0] v);
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (v[(ptr + off) % NUM_REQ]) return (ptr + off) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic int sat(int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    function automatic logic [20:0] rand21();
        return 21'($urandom());
    endfunction

    // Monitor: push on accept, pop and compare on output transfer.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_words = 0;
            m_corr  = 0;
            m_unc   = 0;
            rr_ptr  = NUM_REQ - 1;
            have_prev = 1'b0;
            check("ready_in_reset", 32'(bus.req_ready), 0);
        end else begin
            check("ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    check("rr_grant", i, rr_expect(rr_ptr, bus.req_valid));
                    rr_ptr = i;
                    sb.push_back(model(bus.req_cw[i*21 +: 21], i));
                end
            end
            if (have_prev && prev_stall) begin
                check("hold_stable",
                      {5'b0, bus.out_data, bus.out_syndrome, bus.out_corrected,
                       bus.out_uncorr, 3'(bus.out_src)}, prev_sig);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", 32'(bus.out_data), 32'(e.data));
                    check("out_syndrome", 32'(bus.out_syndrome), 32'(e.syn));
                    check("out_corrected", 32'(bus.out_corrected), 32'(e.corr));
                    check("out_uncorr", 32'(bus.out_uncorr), 32'(e.unc));
                    check("out_src", 32'(bus.out_src), 32'(e.src));
                    m_words = sat(m_words);
                    if (e.corr) m_corr = sat(m_corr);
                    if (e.unc)  m_unc  = sat(m_unc);
                end
            end
            if (bus.stat_clr) begin
                m_words = 0;
                m_corr  = 0;
                m_unc   = 0;
            end
            have_prev  = 1'b1;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_sig   = {5'b0, bus.out_data, bus.out_syndrome, bus.out_corrected,
                          bus.out_uncorr, 3'(bus.out_src)};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(int idx, logic [20:0] cw);
        logic ok;
        ok = 1'b0;
        tick();
        bus.req_valid = '0;
        bus.req_valid[idx] = 1'b1;
        bus.req_cw[idx*21 +: 21] = cw;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            ok = bus.req_ready[idx];
        end
        check("accept_timeout", 32'(ok), 1);
        tick();
        bus.req_valid = '0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            done = (sb.size() == 0);
        end
        check("drain_timeout", 32'(done), 1);
        tick();
    endtask

    task automatic check_stats(string tag);
        check({tag, "_words"},  32'(bus.stat_words),  m_words);
        check({tag, "_corr"},   32'(bus.stat_corr),   m_corr);
        check({tag, "_uncorr"}, 32'(bus.stat_uncorr), m_unc);
    endtask

    initial begin
        int acc;
        logic ok;

        // Reset with both requesters asking: nothing may be granted.
        rst           = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_cw    = '0;
        bus.out_ready = 1'b1;
        bus.stat_clr  = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_fields", {bus.out_data, bus.out_syndrome, bus.out_corrected,
                                 bus.out_uncorr, 3'(bus.out_src)}, 0);
        check("rst_stat_words", 32'(bus.stat_words), 0);
        check("rst_stat_corr", 32'(bus.stat_corr), 0);
        check("rst_stat_uncorr", 32'(bus.stat_uncorr), 0);
        bus.req_valid = '0;
        rst = 1'b0;

        // Clean word, including the two-edge latency.
        send_one(0, 21'h000000);
        @(negedge clk);
        check("latency_s1_only", 32'(bus.out_valid), 0);
        @(negedge clk);
        check("latency_s2_valid", 32'(bus.out_valid), 1);
        drain();
        check("clean_words", 32'(bus.stat_words), 1);

        // Single-bit data errors at positions 3 and 15.
        send_one(0, 21'h000004);
        send_one(1, 21'h004000);
        drain();
        check("corr_count", 32'(bus.stat_corr), 2);
        check("corr_words", 32'(bus.stat_words), 3);

        // Double error aliasing to syndrome 22.
        send_one(0, 21'h100004);
        drain();
        check("uncorr_count", 32'(bus.stat_uncorr), 1);
        check("uncorr_words", 32'(bus.stat_words), 4);
        check_stats("after_directed");

        // Both requesters valid for six cycles: one grant every cycle.
        tick();
        bus.req_valid = 2'b11;
        for (int c = 0; c < 6; c++) begin
            bus.req_cw = {rand21(), rand21()};
            @(negedge clk);
            check("arb_one_ready", $countones(bus.req_ready), 1);
            tick();
        end
        bus.req_valid = '0;
        drain();
        check("arb_words", 32'(bus.stat_words), 10);
        check_stats("after_arb");

        // Backpressure: only S1 and S2 may fill, then req_ready drops.
        bus.out_ready = 1'b0;
        bus.req_valid = 2'b11;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            bus.req_cw = {rand21(), rand21()};
            @(negedge clk);
            acc += $countones(bus.req_ready);
            tick();
        end
        @(negedge clk);
        check("bp_ready_low", 32'(bus.req_ready), 0);
        check("bp_accepts", acc, 2);
        tick();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            bus.req_cw = {rand21(), rand21()};
            tick();
        end
        bus.req_valid = '0;
        drain();
        check("bp_words", 32'(bus.stat_words), 14);
        check_stats("after_bp");

        // Burst past the counter ceiling.
        bus.req_valid = 2'b11;
        for (int c = 0; c < 8; c++) begin
            bus.req_cw = {rand21(), rand21()};
            tick();
        end
        bus.req_valid = '0;
        drain();
        check("sat_words", 32'(bus.stat_words), CNT_MAX);
        check_stats("after_sat");

        // Clear coincident with a transfer: that word is not counted.
        send_one(1, rand21());
        tick();
        check("clr_has_transfer", 32'(bus.out_valid && bus.out_ready), 1);
        bus.stat_clr = 1'b1;
        tick();
        bus.stat_clr = 1'b0;
        check("clr_words", 32'(bus.stat_words), 0);
        check("clr_corr", 32'(bus.stat_corr), 0);
        check("clr_uncorr", 32'(bus.stat_uncorr), 0);

        // Reset with both stages full.
        bus.out_ready = 1'b0;
        bus.req_valid = 2'b11;
        for (int c = 0; c < 3; c++) begin
            bus.req_cw = {rand21(), rand21()};
            tick();
        end
        check("pre_rst_full", 32'(bus.out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 0);
        check("mid_rst_words", 32'(bus.stat_words), 0);
        @(negedge clk);
        check("first_grant_after_rst", 32'(bus.req_ready), 32'b01);
        tick();
        bus.req_valid = '0;
        drain();
        check("final_sb_empty", sb.size(), 0);
        check_stats("final");

        ok = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
